// File: rtl/cnn_pkg.sv
// Shared constants and row helpers for the CNN row datapath.
// A row is array_size words packed LSB-first: word k sits at [k*DATA_SIZE +: DATA_SIZE].
package cnn_pkg;

    localparam int ARRAY_SIZE = 9;
    localparam int DATA_SIZE  = 16;

    typedef logic [DATA_SIZE-1:0]            word_t;
    typedef logic [ARRAY_SIZE*DATA_SIZE-1:0] row_t;

    function automatic word_t row_word(input row_t row, input int unsigned k);
        return row[k*DATA_SIZE +: DATA_SIZE];
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// One systolic lane: `delay` shift stages of {valid, word} followed by an output register,
// so total latency from in_* to out_* is delay+1 cycles.
module skew_delay_line
    import cnn_pkg::*;
#(
    parameter int data_size = DATA_SIZE,
    parameter int delay     = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_vld,
    input  logic [data_size-1:0] in_word,
    output logic                 out_vld,
    output logic [data_size-1:0] out_word
);

    logic [data_size:0] tail_s;

    if (delay == 0) begin : g_direct
        assign tail_s = {in_vld, in_word};
    end else begin : g_pipe
        logic [data_size:0] stage_r [delay];

        // Shift {valid, word} one stage per cycle; clr empties the lane.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < delay; i++) begin
                    stage_r[i] <= {(data_size+1){1'b0}};
                end
            end else if (clr) begin
                for (int i = 0; i < delay; i++) begin
                    stage_r[i] <= {(data_size+1){1'b0}};
                end
            end else begin
                stage_r[0] <= {in_vld, in_word};
                for (int i = 1; i < delay; i++) begin
                    stage_r[i] <= stage_r[i-1];
                end
            end
        end

        assign tail_s = stage_r[delay-1];
    end

    // Output register: lane outputs are always flop-driven.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            out_word <= {data_size{1'b0}};
        end else if (clr) begin
            out_vld  <= 1'b0;
            out_word <= {data_size{1'b0}};
        end else begin
            out_vld  <= tail_s[data_size];
            out_word <= tail_s[data_size-1:0];
        end
    end

endmodule

// File: rtl/skewed_row_fifo.sv
// Row FIFO feeding one row-buffer mux input; rows leave diagonally skewed so that
// lane k of a row read in cycle t appears in cycle t+1+k at the systolic array edge.
module skewed_row_fifo
    import cnn_pkg::*;
#(
    parameter  int array_size = ARRAY_SIZE,
    parameter  int data_size  = DATA_SIZE,
    parameter  int depth      = 16,
    localparam int ptr_w      = $clog2(depth)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic                            wr_valid,
    output logic                            wr_ready,
    input  logic [data_size*array_size-1:0] wr_data,
    input  logic                            rd_en,
    output logic [data_size*array_size-1:0] out_data,
    output logic [array_size-1:0]           out_lane_vld,
    output logic [ptr_w:0]                  count,
    output logic                            empty,
    output logic                            full
);

    localparam logic [ptr_w-1:0] ptr_zero = {ptr_w{1'b0}};
    localparam logic [ptr_w-1:0] ptr_one  = ptr_w'(1);
    localparam logic [ptr_w:0]   cnt_zero = {(ptr_w+1){1'b0}};
    localparam logic [ptr_w:0]   cnt_one  = (ptr_w+1)'(1);
    localparam logic [ptr_w:0]   cnt_full = (ptr_w+1)'(depth);

    logic [data_size*array_size-1:0] mem_r [depth];
    logic [ptr_w-1:0]                wr_ptr_r;
    logic [ptr_w-1:0]                rd_ptr_r;
    logic [ptr_w:0]                  count_r;
    logic                            empty_r;
    logic                            full_r;

    logic                            wr_acc_s;
    logic                            rd_acc_s;
    logic [ptr_w:0]                  count_nxt_s;
    logic [data_size*array_size-1:0] rd_row_s;

    // Handshake acceptance and next occupancy; flush overrides both ports.
    always_comb begin
        wr_acc_s    = wr_valid && !full_r && !flush;
        rd_acc_s    = rd_en && !empty_r && !flush;
        count_nxt_s = count_r;
        if (flush) begin
            count_nxt_s = cnt_zero;
        end else if (wr_acc_s && !rd_acc_s) begin
            count_nxt_s = count_r + cnt_one;
        end else if (rd_acc_s && !wr_acc_s) begin
            count_nxt_s = count_r - cnt_one;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Pointers and registered status; flags come from next count so they track count exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= ptr_zero;
            rd_ptr_r <= ptr_zero;
            count_r  <= cnt_zero;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
        end else if (flush) begin
            wr_ptr_r <= ptr_zero;
            rd_ptr_r <= ptr_zero;
            count_r  <= cnt_zero;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + ptr_one;
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + ptr_one;
            end
            count_r <= count_nxt_s;
            empty_r <= (count_nxt_s == cnt_zero);
            full_r  <= (count_nxt_s == cnt_full);
        end
    end

    // Row storage: contents are never reset, only pointers guard what is readable.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // A cycle without an accepted read feeds an all-zero bubble into the skew pipe.
    always_comb begin
        if (rd_acc_s) begin
            rd_row_s = mem_r[rd_ptr_r];
        end else begin
            rd_row_s = {(data_size*array_size){1'b0}};
        end
    end

    for (genvar k = 0; k < array_size; k++) begin : g_lane
        skew_delay_line #(
            .data_size (data_size),
            .delay     (k)
        ) u_line (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (flush),
            .in_vld   (rd_acc_s),
            .in_word  (rd_row_s[k*data_size +: data_size]),
            .out_vld  (out_lane_vld[k]),
            .out_word (out_data[k*data_size +: data_size])
        );
    end

    assign wr_ready = !full_r;
    assign count    = count_r;
    assign empty    = empty_r;
    assign full     = full_r;

endmodule

// File: tb/tb_skewed_row_fifo.sv
// Directed self-checking bench for skewed_row_fifo (9 lanes x 16 bits, depth 16).
module tb_skewed_row_fifo;
    import cnn_pkg::*;

    localparam int AS = 9;
    localparam int DS = 16;
    localparam int PW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            wr_valid;
    logic            wr_ready;
    logic [DS*AS-1:0] wr_data;
    logic            rd_en;
    logic [DS*AS-1:0] out_data;
    logic [AS-1:0]   out_lane_vld;
    logic [PW:0]     count;
    logic            empty;
    logic            full;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    skewed_row_fifo #(.array_size(AS), .data_size(DS), .depth(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .out_data     (out_data),
        .out_lane_vld (out_lane_vld),
        .count        (count),
        .empty        (empty),
        .full         (full)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pat(input int m);
        return {m[7:0], m[7:0]};
    endfunction

    function automatic logic [DS*AS-1:0] row_of(input int m);
        logic [DS*AS-1:0] r;
        for (int k = 0; k < AS; k++) r[k*DS +: DS] = pat(m);
        return r;
    endfunction

    task automatic write_rows(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_data  = row_of(base + i);
            tick;
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; flush = 1'b0; wr_valid = 1'b0; rd_en = 1'b0; wr_data = '0;
        tick;
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (empty !== 1'b1 || full !== 1'b0 || wr_ready !== 1'b1) begin errors++; $display("FAIL reset_flags: empty=%b full=%b wr_ready=%b expected 1 0 1", empty, full, wr_ready); end
        checks++; if (out_lane_vld !== 9'h000 || out_data !== '0) begin errors++; $display("FAIL reset_out: vld=%h data=%h expected 0", out_lane_vld, out_data); end
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_fill_wrap;
        write_rows(0, 16);
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL fill_count: got %0d expected 16", count); end
        checks++; if (full !== 1'b1 || wr_ready !== 1'b0 || empty !== 1'b0) begin errors++; $display("FAIL fill_flags: full=%b wr_ready=%b empty=%b expected 1 0 0", full, wr_ready, empty); end
        wr_valid = 1'b1; wr_data = row_of(99);
        tick;
        wr_valid = 1'b0;
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL write17_held: count=%0d expected 16", count); end
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick;
            checks++; if (row_word(out_data, 0) !== pat(i) || out_lane_vld[0] !== 1'b1) begin errors++; $display("FAIL fill_read%0d: lane0=%h vld0=%b expected %h 1", i, row_word(out_data, 0), out_lane_vld[0], pat(i)); end
        end
        rd_en = 1'b0;
        checks++; if (count !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL drain_empty: count=%0d empty=%b expected 0 1", count, empty); end
        write_rows(16, 16);
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick;
            checks++; if (row_word(out_data, 0) !== pat(16 + i)) begin errors++; $display("FAIL wrap_read%0d: lane0=%h expected %h", i, row_word(out_data, 0), pat(16 + i)); end
        end
        rd_en = 1'b0;
        repeat (10) tick;
    endtask

    task automatic test_skew;
        logic [DS*AS-1:0] exp_d;
        logic [AS-1:0]    exp_v;
        wr_valid = 1'b1;
        for (int k = 0; k < AS; k++) wr_data[k*DS +: DS] = 16'(16'h0100 + k);
        tick;
        wr_valid = 1'b0;
        tick;
        rd_en = 1'b1;
        tick;
        rd_en = 1'b0;
        for (int j = 0; j <= 10; j++) begin
            exp_d = '0;
            exp_v = '0;
            if (j < AS) begin
                exp_v[j] = 1'b1;
                exp_d[j*DS +: DS] = 16'(16'h0100 + j);
            end
            checks++; if (out_lane_vld !== exp_v) begin errors++; $display("FAIL skew_vld_t%0d: got %h expected %h", j + 1, out_lane_vld, exp_v); end
            checks++; if (out_data !== exp_d) begin errors++; $display("FAIL skew_data_t%0d: got %h expected %h", j + 1, out_data, exp_d); end
            tick;
        end
    endtask

    task automatic test_back_to_back;
        logic [DS*AS-1:0] exp_d;
        write_rows(40, 9);
        rd_en = 1'b1;
        for (int j = 0; j < AS; j++) begin
            tick;
            checks++; if (out_lane_vld !== (9'h1FF >> (8 - j))) begin errors++; $display("FAIL stream_ramp%0d: vld=%h expected %h", j, out_lane_vld, 9'h1FF >> (8 - j)); end
        end
        rd_en = 1'b0;
        for (int k = 0; k < AS; k++) exp_d[k*DS +: DS] = pat(48 - k);
        checks++; if (out_data !== exp_d) begin errors++; $display("FAIL stream_full_data: got %h expected %h", out_data, exp_d); end
        for (int m = 1; m <= AS; m++) begin
            tick;
            checks++; if (out_lane_vld !== 9'(9'h1FF << m)) begin errors++; $display("FAIL stream_drain%0d: vld=%h expected %h", m, out_lane_vld, 9'(9'h1FF << m)); end
        end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL stream_count: got %0d expected 0", count); end
    endtask

    task automatic test_empty_rw;
        rd_en = 1'b1;
        tick;
        rd_en = 1'b0;
        checks++; if (count !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL empty_read_count: count=%0d empty=%b expected 0 1", count, empty); end
        checks++; if (out_lane_vld[0] !== 1'b0 || row_word(out_data, 0) !== 16'h0000) begin errors++; $display("FAIL empty_read_bubble: vld0=%b lane0=%h expected 0 0", out_lane_vld[0], row_word(out_data, 0)); end
        write_rows(60, 3);
        checks++; if (count !== 5'd3) begin errors++; $display("FAIL rw_pre_count: got %0d expected 3", count); end
        rd_en = 1'b1; wr_valid = 1'b1; wr_data = row_of(63);
        tick;
        wr_valid = 1'b0;
        checks++; if (count !== 5'd3) begin errors++; $display("FAIL rw_count: got %0d expected 3", count); end
        checks++; if (row_word(out_data, 0) !== pat(60) || out_lane_vld[0] !== 1'b1) begin errors++; $display("FAIL rw_data: lane0=%h expected %h", row_word(out_data, 0), pat(60)); end
        for (int i = 1; i <= 3; i++) begin
            tick;
            checks++; if (row_word(out_data, 0) !== pat(60 + i)) begin errors++; $display("FAIL rw_read%0d: lane0=%h expected %h", i, row_word(out_data, 0), pat(60 + i)); end
        end
        rd_en = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rw_empty: got %b expected 1", empty); end
        repeat (10) tick;
    endtask

    task automatic test_flush;
        write_rows(70, 10);
        rd_en = 1'b1;
        repeat (3) tick;
        checks++; if (count !== 5'd7) begin errors++; $display("FAIL flush_pre_count: got %0d expected 7", count); end
        flush = 1'b1; wr_valid = 1'b1; wr_data = row_of(99);
        tick;
        flush = 1'b0; wr_valid = 1'b0; rd_en = 1'b0;
        checks++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL flush_count: count=%0d empty=%b full=%b expected 0 1 0", count, empty, full); end
        checks++; if (out_lane_vld !== 9'h000 || out_data !== '0) begin errors++; $display("FAIL flush_out: vld=%h data=%h expected 0", out_lane_vld, out_data); end
        tick;
        checks++; if (out_lane_vld !== 9'h000) begin errors++; $display("FAIL flush_pipe: vld=%h expected 000", out_lane_vld); end
        write_rows(80, 1);
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL flush_drop: count=%0d expected 1", count); end
        rd_en = 1'b1;
        tick;
        rd_en = 1'b0;
        checks++; if (row_word(out_data, 0) !== pat(80)) begin errors++; $display("FAIL flush_after: lane0=%h expected %h", row_word(out_data, 0), pat(80)); end
        repeat (10) tick;
    endtask

    task automatic test_reset_midstream;
        write_rows(90, 6);
        rd_en = 1'b1;
        tick;
        rd_en = 1'b0;
        checks++; if (count !== 5'd5 || out_lane_vld !== 9'h001) begin errors++; $display("FAIL mid_pre: count=%0d vld=%h expected 5 001", count, out_lane_vld); end
        rst_n = 1'b0;
        #1;
        checks++; if (count !== 5'd0 || empty !== 1'b1 || wr_ready !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL mid_reset_flags: count=%0d empty=%b wr_ready=%b full=%b expected 0 1 1 0", count, empty, wr_ready, full); end
        checks++; if (out_lane_vld !== 9'h000 || out_data !== '0) begin errors++; $display("FAIL mid_reset_out: vld=%h data=%h expected 0", out_lane_vld, out_data); end
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_fill_wrap;
        test_skew;
        test_back_to_back;
        test_empty_rw;
        test_flush;
        test_reset_midstream;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
